// File: rtl/rv32i_fetch.sv
// rv32i fetch stage: owns the PC, keeps one imem request in flight, buffers returned
// words in a small FIFO for decode, and flushes/restarts on execute-stage redirects.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [1:0]  fsm_state
);

  // Handshakes: imem_req/imem_addr hold until a cycle with imem_ack=1 (one request
  // outstanding); decode takes the head on any cycle with out_valid=1 and out_ready=1.

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  // Next PC to request from IDLE, or the saved redirect target while in KILL.
  logic [31:0] pc_q, pc_d;

  logic [AW:0] rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d, occ_d;
  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [31:0] pc_mem    [FIFO_DEPTH];

  logic        pop, push, can_issue;
  logic [31:0] redir_pc, addr_inc;
  logic        unused_bits;

  assign unused_bits = &{1'b0, redirect_pc[1:0]};

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign fsm_state = state_q;

  assign out_valid = (wr_ptr != rd_ptr);
  assign out_instr = instr_mem[rd_ptr[AW-1:0]];
  assign out_pc    = pc_mem[rd_ptr[AW-1:0]];

  assign pop      = out_valid & out_ready;
  // Words returned in KILL, or alongside a redirect, are stale and never buffered.
  assign push     = (state_q == S_REQ) & imem_ack & ~redirect_valid;
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign addr_inc = addr_q + 32'd4;

  always_comb begin
    rd_ptr_d = rd_ptr;
    wr_ptr_d = wr_ptr;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr + (AW+1)'(pop);
      wr_ptr_d = wr_ptr + (AW+1)'(push);
    end
  end

  // Issue only if the buffer still has room after this edge's push and pop.
  assign occ_d     = wr_ptr_d - rd_ptr_d;
  assign can_issue = (occ_d < DEPTH_P);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      if (imem_req && !imem_ack) begin
        state_d = S_KILL;
        pc_d    = redir_pc;
      end else begin
        state_d = S_REQ;
        addr_d  = redir_pc;
        pc_d    = redir_pc;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (can_issue) begin
            state_d = S_REQ;
            addr_d  = pc_q;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            pc_d = addr_inc;
            if (can_issue) begin
              addr_d = addr_inc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_KILL: begin
          if (imem_ack) begin
            state_d = S_REQ;
            addr_d  = pc_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      rd_ptr  <= rd_ptr_d;
      wr_ptr  <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr[AW-1:0]] <= imem_rdata;
      pc_mem[wr_ptr[AW-1:0]]    <= addr_q;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the fetch stage.
module tb_rv32i_fetch;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [1:0]  fsm_state;

  rv32i_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending request (address, stale flag, redirect target) and a queue of
  // delivered {pc, instr} entries.
  logic        m_req;
  logic        m_stale;
  logic [31:0] m_addr, m_next, m_target;
  logic [63:0] exp_q[$];

  task automatic model_reset();
    exp_q.delete();
    m_req = 1'b0; m_stale = 1'b0;
    m_addr = RPC; m_next = RPC; m_target = RPC;
  endtask

  task automatic model_step();
    logic ack;
    logic [31:0] tgt;
    ack = m_req && imem_ack;
    if (redirect_valid) begin
      exp_q.delete();
      tgt = {redirect_pc[31:2], 2'b00};
      if (m_req && !imem_ack) begin
        m_stale = 1'b1; m_target = tgt;
      end else begin
        m_stale = 1'b0; m_req = 1'b1; m_addr = tgt;
      end
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (ack && m_stale) begin
        m_stale = 1'b0; m_addr = m_target;
      end else if (ack) begin
        exp_q.push_back({m_addr, mem_word(m_addr)});
        m_next = m_addr + 32'd4;
        if (exp_q.size() < DEPTH) m_addr = m_next;
        else m_req = 1'b0;
      end else if (!m_req && exp_q.size() < DEPTH) begin
        m_req = 1'b1; m_addr = m_next;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0][63:32]);
      check("out_instr", out_instr, exp_q[0][31:0]);
    end
  end

  task automatic step(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
    imem_ack       = ack;
    imem_rdata     = ack ? mem_word(imem_addr) : $urandom;
    out_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #3 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_valid_drop", 32'(out_valid), 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'hFFFF_FFF8);

    // Continuous acks: addresses wrap, outputs trail by one cycle with no bubbles.
    step(1, 1, 0, 0);
    check("stream_addr1", imem_addr, 32'hFFFF_FFFC);
    check("stream_pc1", out_pc, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    check("stream_addr2", imem_addr, 32'h0000_0000);
    check("stream_pc2", out_pc, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("stream_pc3", out_pc, 32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      check("no_bubble", 32'(out_valid), 32'd1);
    end

    // Slow memory: three wait cycles per fetch.
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
    end

    // Backpressure from a known address.
    step(0, 1, 1, 32'h0000_0200);
    step(1, 1, 0, 0);
    check("bp_start_addr", imem_addr, 32'h0000_0200);
    repeat (10) step(1, 0, 0, 0);
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_head", out_pc, 32'h0000_0200);
    step(0, 1, 0, 0);
    check("bp_resume_req", 32'(imem_req), 32'd1);
    check("bp_resume_addr", imem_addr, 32'h0000_0208);
    check("bp_second", out_pc, 32'h0000_0204);

    // Redirect while a request is pending: the stale word must be discarded.
    step(0, 1, 1, 32'h0000_0010);
    check("kill_hold_addr", imem_addr, 32'h0000_0208);
    step(1, 1, 0, 0);
    check("kill_reissue", imem_addr, 32'h0000_0010);
    step(0, 1, 1, 32'h0000_0103);
    check("kill2_hold", imem_addr, 32'h0000_0010);
    step(0, 1, 0, 0);
    check("kill2_hold_b", imem_addr, 32'h0000_0010);
    step(1, 1, 0, 0);
    check("kill2_target", imem_addr, 32'h0000_0100);
    check("kill2_no_out", 32'(out_valid), 32'd0);
    step(1, 1, 0, 0);
    check("kill2_first_pc", out_pc, 32'h0000_0100);

    // Redirect coinciding with an ack, then with a full buffer.
    step(1, 0, 1, 32'h0000_0400);
    check("rd_ack_flush", 32'(out_valid), 32'd0);
    check("rd_ack_addr", imem_addr, 32'h0000_0400);
    step(1, 1, 0, 0);
    check("rd_ack_first", out_pc, 32'h0000_0400);
    step(1, 0, 0, 0);
    check("full_req_low", 32'(imem_req), 32'd0);
    step(1, 0, 1, 32'h0000_0802);
    check("full_flush", 32'(out_valid), 32'd0);
    check("full_redir_addr", imem_addr, 32'h0000_0800);

    // Reset mid-stream.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    async_reset_pulse();
    step(0, 1, 0, 0);
    check("restart_addr", imem_addr, RPC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        async_reset_pulse();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
             $urandom_range(0, 99) < 4,
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : 32'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
